mem_read_align: RTL and testbench

//  Load-side counterpart of the store byte-lane aligner: issues the data-memory

---
 rtl/mem_read_align_pkg.sv | 48 ++++
 rtl/load_byte_extract.sv | 30 +++
 rtl/mem_read_align.sv | 143 ++++++++++++++
 tb/tb_mem_read_align.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_align_pkg.sv
// Shared RV32I load types: funct3 encodings, aligner FSM states and lane helpers.
package rv32i_types;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        DONE = 2'd3
    } mra_state_t;

    // True for the five load encodings RV32I defines.
    function automatic logic is_legal_load(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Unshifted byte-lane mask for the access size (1, 3 or F).
    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        logic [7:0] m;
        case (f3)
            F3_LB, F3_LBU: m = 8'h01;
            F3_LH, F3_LHU: m = 8'h03;
            F3_LW:         m = 8'h0F;
            default:       m = 8'h00;
        endcase
        return m;
    endfunction

    // A load crosses a word boundary when its shifted mask spills into lanes 4..7.
    function automatic logic is_crossing(input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] m;
        m = size_mask(f3) << off;
        return |m[7:4];
    endfunction

endpackage

// File: rtl/load_byte_extract.sv
// Combinational byte extractor: selects the addressed bytes from two buffered
// words (buf1 above buf0, byte 0 = lowest address) and extends to 32 bits.
module load_byte_extract
    import rv32i_types::*;
(
    input  logic [63:0] bytes_in,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] low;

    // Drop the bytes below the load address so the loaded value starts at bit 0.
    assign low = 32'(bytes_in >> {offset, 3'b000});

    // Size selection and sign/zero extension; illegal encodings yield zero.
    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = {{24{low[7]}}, low[7:0]};
            F3_LH:   result = {{16{low[15]}}, low[15:0]};
            F3_LW:   result = low;
            F3_LBU:  result = {24'h0, low[7:0]};
            F3_LHU:  result = {16'h0, low[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_read_align.sv
// RV32I load aligner: issues one or two word reads for a load, merges the
// returned bytes and produces the extended result with a one-cycle valid.
//
// Handshakes: load_req is taken only in a cycle where busy is low (no queuing);
// mem_read stays high, with stable address and enables, until the cycle in
// which mem_resp is high, and that cycle's mem_rdata is the read data.
module mem_read_align
    import rv32i_types::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        load_err,
    output mra_state_t  dbg_state
);

    mra_state_t  state, state_next;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] buf0_q;
    logic [31:0] load_data_q;
    logic        load_err_q;

    logic        req_reject;
    logic        cur_cross;
    logic [7:0]  be_mask;
    logic [31:0] base_addr;
    logic [31:0] extract_buf0;
    logic [31:0] extract_result;

    // Rejected requests never touch memory: bad encoding, or a crossing load
    // when splitting is disabled.
    assign req_reject   = !is_legal_load(funct3) ||
                          (is_crossing(funct3, addr[1:0]) && !SPLIT_EN);
    assign cur_cross    = is_crossing(f3_q, addr_q[1:0]);
    assign be_mask      = size_mask(f3_q) << addr_q[1:0];
    assign base_addr    = {addr_q[31:2], 2'b00};
    // During the first read the word is used straight from the bus so an
    // aligned load completes without an extra buffering cycle.
    assign extract_buf0 = (state == RD0) ? mem_rdata : buf0_q;

    load_byte_extract u_extract (
        .bytes_in ({mem_rdata, extract_buf0}),
        .offset   (addr_q[1:0]),
        .funct3   (f3_q),
        .result   (extract_result)
    );

    // State register; reset aborts any load in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Request latch, first-word buffer and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_q        <= '0;
            addr_q      <= '0;
            buf0_q      <= '0;
            load_data_q <= '0;
            load_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_req) begin
                        f3_q   <= funct3;
                        addr_q <= addr;
                        if (req_reject) begin
                            load_data_q <= '0;
                            load_err_q  <= 1'b1;
                        end
                    end
                end
                RD0: begin
                    if (mem_resp) begin
                        buf0_q <= mem_rdata;
                        if (!cur_cross) begin
                            load_data_q <= extract_result;
                            load_err_q  <= 1'b0;
                        end
                    end
                end
                RD1: begin
                    if (mem_resp) begin
                        load_data_q <= extract_result;
                        load_err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and state-decoded memory/handshake outputs.
    always_comb begin
        state_next      = state;
        mem_read        = 1'b0;
        mem_address     = '0;
        mem_byte_enable = '0;
        load_valid      = 1'b0;
        case (state)
            IDLE: begin
                if (load_req) state_next = req_reject ? DONE : RD0;
            end
            RD0: begin
                mem_read        = 1'b1;
                mem_address     = base_addr;
                mem_byte_enable = be_mask[3:0];
                if (mem_resp) state_next = cur_cross ? RD1 : DONE;
            end
            RD1: begin
                mem_read        = 1'b1;
                mem_address     = base_addr + 32'd4;
                mem_byte_enable = be_mask[7:4];
                if (mem_resp) state_next = DONE;
            end
            DONE: begin
                load_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign load_data = load_data_q;
    assign load_err  = load_err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_read_align.sv
// Bench for mem_read_align: directed vector table, hand-written multi-cycle
// sequences (reset abort, SPLIT_EN=0 instance) and a randomized run against a
// byte-level memory-image reference model.
module tb_mem_read_align;
    import rv32i_types::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT with splitting enabled
    logic        load_req = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic        busy, mem_read, load_valid, load_err;
    logic [31:0] mem_address, load_data;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    mra_state_t  dbg_state;

    // DUT with splitting disabled
    logic        load_req2 = 1'b0;
    logic [2:0]  funct3_2 = '0;
    logic [31:0] addr2 = '0;
    logic        busy2, mem_read2, load_valid2, load_err2;
    logic [31:0] mem_address2, load_data2;
    logic [3:0]  mem_byte_enable2;
    logic        mem_resp2 = 1'b0;
    mra_state_t  dbg_state2;

    mem_read_align #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .funct3(funct3), .addr(addr),
        .busy(busy), .mem_read(mem_read), .mem_address(mem_address),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .load_data(load_data), .load_valid(load_valid), .load_err(load_err),
        .dbg_state(dbg_state)
    );

    mem_read_align #(.SPLIT_EN(1'b0)) dut_nosplit (
        .clk(clk), .rst(rst), .load_req(load_req2), .funct3(funct3_2), .addr(addr2),
        .busy(busy2), .mem_read(mem_read2), .mem_address(mem_address2),
        .mem_byte_enable(mem_byte_enable2), .mem_rdata(mem_rdata), .mem_resp(mem_resp2),
        .load_data(load_data2), .load_valid(load_valid2), .load_err(load_err2),
        .dbg_state(dbg_state2)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];   // {load_err, load_data}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Load seen as bytes of a little-endian memory image {w1,w0} starting at
    // the aligned address; returns {err, data}.
    function automatic logic [32:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w0, input logic [31:0] w1,
                                               input bit split);
        int size;
        bit sgn;
        int off;
        logic [63:0] img;
        logic [31:0] v;
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: begin size = 4; sgn = 1'b0; end
            3'b100: begin size = 1; sgn = 1'b0; end
            3'b101: begin size = 2; sgn = 1'b0; end
            default: begin size = 0; sgn = 1'b0; end
        endcase
        off = int'(a % 4);
        if (size == 0) return {1'b1, 32'h0};
        if (off + size > 4 && !split) return {1'b1, 32'h0};
        img = {w1, w0};
        v = '0;
        for (int i = 0; i < size; i++)
            v = v | (32'((img >> (8 * (off + i))) & 64'hFF) << (8 * i));
        if (sgn && v[8 * size - 1])
            for (int i = 8 * size; i < 32; i++) v[i] = 1'b1;
        return {1'b0, v};
    endfunction

    // Expected accesses: lanes touched by bytes addr..addr+size-1.
    task automatic model_acc(input logic [2:0] f3, input logic [31:0] a, input bit split,
                             output int nacc, output logic [3:0] be0, output logic [3:0] be1);
        int size;
        int off;
        logic [7:0] m;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        off = int'(a % 4);
        m = '0;
        for (int i = 0; i < size; i++) m[off + i] = 1'b1;
        if (size == 0 || (off + size > 4 && !split)) begin
            nacc = 0; be0 = '0; be1 = '0;
        end else begin
            be0 = m[3:0];
            be1 = m[7:4];
            nacc = (m[7:4] != 0) ? 2 : 1;
        end
    endtask

    // ---------------- driver ----------------
    // Issues one load on the split DUT, acts as memory with 'waits' stall
    // cycles per read and checks accesses, latency and result.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input int waits, input bit pulse, input logic [32:0] exp_res,
                            input logic [3:0] be0, input logic [3:0] be1,
                            input int nacc, input int lat);
        int acc_idx;
        int wait_cnt;
        bit done;
        logic [31:0] exp_addr;
        logic [32:0] exp_v;
        acc_idx = 0;
        wait_cnt = 0;
        done = 1'b0;
        exp_q.push_back(exp_res);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", load_valid, 0);
        load_req = 1'b1;
        funct3 = f3;
        addr = a;
        mem_resp = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            chk("busy", busy, 1);
            if (acc_idx < nacc) chk("mem_read_held", mem_read, 1);
            if (mem_read && acc_idx < nacc) begin
                exp_addr = (a & 32'hFFFF_FFFC) + ((acc_idx == 0) ? 32'd0 : 32'd4);
                chk("mem_address", mem_address, exp_addr);
                chk("byte_enable", mem_byte_enable, (acc_idx == 0) ? be0 : be1);
                if (wait_cnt == waits) begin
                    mem_resp = 1'b1;
                    mem_rdata = (acc_idx == 0) ? w0 : w1;
                    acc_idx++;
                    wait_cnt = 0;
                end else begin
                    mem_resp = 1'b0;
                    mem_rdata = $urandom;
                    wait_cnt++;
                end
            end else begin
                if (mem_read) chk("unexpected_mem_read", mem_read, 0);
                mem_resp = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if (load_valid) begin
                exp_v = exp_q.pop_front();
                chk("load_result", {load_err, load_data}, exp_v);
                chk("latency", c, lat);
                chk("accesses", acc_idx, nacc);
                done = 1'b1;
            end
            if (pulse) begin
                load_req = 1'($urandom_range(0, 1));
                funct3 = 3'($urandom_range(0, 7));
                addr = $urandom;
            end else begin
                load_req = 1'b0;
            end
        end
        load_req = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no load_valid within 60 cycles for addr %0h", a);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_byte_enable"}, mem_byte_enable, 0);
        chk({tag, "_load_data"}, load_data, 0);
        chk({tag, "_load_valid"}, load_valid, 0);
        chk({tag, "_load_err"}, load_err, 0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] w0;
        logic [31:0] w1;
        int          waits;
        bit          pulse;
        logic [32:0] exp_res;
        logic [3:0]  be0;
        logic [3:0]  be1;
        int          nacc;
        int          lat;
    } vec_t;

    vec_t vecs[11];
    logic [2:0] f3_pool[10];

    initial begin
        vecs[0]  = '{3'b100, 32'h0000_1003, 32'h80AB_CDEF, 32'h0, 0, 1'b0, {1'b0, 32'h0000_0080}, 4'b1000, 4'b0000, 1, 2};
        vecs[1]  = '{3'b000, 32'h0000_1003, 32'h80AB_CDEF, 32'h0, 0, 1'b0, {1'b0, 32'hFFFF_FF80}, 4'b1000, 4'b0000, 1, 2};
        vecs[2]  = '{3'b001, 32'h0000_1002, 32'h80AB_CDEF, 32'h0, 0, 1'b0, {1'b0, 32'hFFFF_80AB}, 4'b1100, 4'b0000, 1, 2};
        vecs[3]  = '{3'b010, 32'h0000_2001, 32'h4433_2211, 32'h8877_6655, 0, 1'b0, {1'b0, 32'h5544_3322}, 4'b1110, 4'b0001, 2, 3};
        vecs[4]  = '{3'b001, 32'hFFFF_FFFF, 32'h1122_3344, 32'h5566_7788, 0, 1'b0, {1'b0, 32'hFFFF_8811}, 4'b1000, 4'b0001, 2, 3};
        vecs[5]  = '{3'b011, 32'h0000_0040, 32'h0, 32'h0, 0, 1'b0, {1'b1, 32'h0}, 4'b0000, 4'b0000, 0, 1};
        vecs[6]  = '{3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0, 3, 1'b1, {1'b0, 32'hDEAD_BEEF}, 4'b1111, 4'b0000, 1, 5};
        vecs[7]  = '{3'b101, 32'h0000_1001, 32'h80AB_CDEF, 32'h0, 0, 1'b0, {1'b0, 32'h0000_ABCD}, 4'b0110, 4'b0000, 1, 2};
        vecs[8]  = '{3'b010, 32'h0000_2002, 32'h4433_2211, 32'h8877_6655, 2, 1'b1, {1'b0, 32'h6655_4433}, 4'b1100, 4'b0011, 2, 7};
        vecs[9]  = '{3'b111, 32'h0000_0010, 32'h0, 32'h0, 0, 1'b1, {1'b1, 32'h0}, 4'b0000, 4'b0000, 0, 1};
        vecs[10] = '{3'b000, 32'h0000_0000, 32'h0000_007F, 32'h0, 0, 1'b0, {1'b0, 32'h0000_007F}, 4'b0001, 4'b0000, 1, 2};
        f3_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b001, 3'b010, 3'b101, 3'b011, 3'b110};

        // Reset asserted asynchronously before any clock edge.
        #3 rst = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++)
            run_load(vecs[i].f3, vecs[i].a, vecs[i].w0, vecs[i].w1, vecs[i].waits,
                     vecs[i].pulse, vecs[i].exp_res, vecs[i].be0, vecs[i].be1,
                     vecs[i].nacc, vecs[i].lat);

        // Reset during RD0 aborts the load; a late response is ignored.
        @(negedge clk);
        load_req = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100; mem_resp = 1'b0;
        @(negedge clk);
        load_req = 1'b0;
        chk("abort_mem_read_before", mem_read, 1);
        rst = 1'b0;
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("late_resp_valid", load_valid, 0);
            chk("late_resp_busy", busy, 0);
            chk("late_resp_data", load_data, 0);
        end
        mem_resp = 1'b0;
        run_load(3'b010, 32'h0, 32'h1234_5678, 32'h0, 0, 1'b0, {1'b0, 32'h1234_5678},
                 4'b1111, 4'b0000, 1, 2);

        // SPLIT_EN=0 instance: aligned LW works, crossing loads are rejected without memory access.
        @(negedge clk);
        load_req2 = 1'b1; funct3_2 = 3'b010; addr2 = 32'h0000_0010;
        @(negedge clk);
        load_req2 = 1'b0;
        chk("ns_mem_read", mem_read2, 1);
        chk("ns_mem_address", mem_address2, 32'h0000_0010);
        chk("ns_byte_enable", mem_byte_enable2, 4'b1111);
        mem_resp2 = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_resp2 = 1'b0;
        chk("ns_lw_valid", load_valid2, 1);
        chk("ns_lw_data", {load_err2, load_data2}, {1'b0, 32'hCAFE_F00D});
        @(negedge clk);
        load_req2 = 1'b1; funct3_2 = 3'b001; addr2 = 32'hFFFF_FFFF;
        @(negedge clk);
        load_req2 = 1'b0;
        chk("ns_lh_mem_read", mem_read2, 0);
        chk("ns_lh_valid", load_valid2, 1);
        chk("ns_lh_result", {load_err2, load_data2}, {1'b1, 32'h0});
        @(negedge clk);
        chk("ns_lh_pulse_end", load_valid2, 0);
        load_req2 = 1'b1; funct3_2 = 3'b010; addr2 = 32'h0000_0005;
        @(negedge clk);
        load_req2 = 1'b0;
        chk("ns_lw_mis_mem_read", mem_read2, 0);
        chk("ns_lw_mis_result", {load_valid2, load_err2, load_data2}, {2'b11, 32'h0});

        // Randomized loads against the memory-image model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, w0, w1;
            int          waits, nacc;
            logic [3:0]  be0, be1;
            f3 = f3_pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            else                           a = $urandom;
            w0 = $urandom;
            w1 = $urandom;
            waits = $urandom_range(0, 2);
            model_acc(f3, a, 1'b1, nacc, be0, be1);
            run_load(f3, a, w0, w1, waits, 1'($urandom_range(0, 1)),
                     model_load(f3, a, w0, w1, 1'b1), be0, be1, nacc,
                     1 + nacc * (waits + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
